// File: rtl/red_mod_p.sv
// red_mod_p: serial reducer from the (8+d)-bit redundant domain back to GF(2^8).
// The input word w = x + r*P is divided by the field polynomial P with one
// quotient bit produced per cycle. The remainder x appears on out_x.
// Optional feature macro: RED_QUOTIENT_EN adds the out_q port and the q register,
// which together expose the recovered mask r.
// Bit ordering is ascending: index 0 is always the highest-degree coefficient.
module red_mod_p #(
  parameter int         d = 4,
  parameter logic [0:8] P = 9'b100011011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:7+d] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:7]   out_x
`ifdef RED_QUOTIENT_EN
  ,
  output logic [0:d-1] out_q
`endif
);

  localparam int SW = $clog2(d + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [0:7+d]   work_r;
  logic [0:7+d]   work_nxt_s;
  logic [SW-1:0]  step_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           last_s;

  // One long-division step at position i. P[0] is 1, so a set leading bit is
  // cleared by the XOR. Bits below i are already zero and are left as they are.
  function automatic logic [0:7+d] div_step(input logic [0:7+d] w,
                                            input logic [SW-1:0] i);
    logic [0:7+d] res;
    logic         sel;
    res = w;
    for (int k = 0; k < d; k++) begin
      sel = (i == SW'(k)) & w[k];
      res[k +: 9] = res[k +: 9] ^ ({9{sel}} & P);
    end
    return res;
  endfunction

  // Next remainder and last-step detection for the current step
  always_comb begin
    work_nxt_s = div_step(work_r, step_r);
    last_s     = (step_r == SW'(d - 1));
  end

  // Control FSM and dividend register; handshake flags are registered with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      work_r      <= '0;
      step_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= in_data;
            step_r     <= '0;
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
          end
        end
        BUSY: begin
          work_r <= work_nxt_s;
          step_r <= step_r + SW'(1);
          if (last_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef RED_QUOTIENT_EN
  logic [0:d-1] q_r;
  logic [0:d-1] q_nxt_s;

  // Capture the leading bit of the current step as the next quotient bit
  always_comb begin
    q_nxt_s = q_r;
    for (int k = 0; k < d; k++) begin
      if (step_r == SW'(k)) begin
        q_nxt_s[k] = work_r[k];
      end else begin
        q_nxt_s[k] = q_r[k];
      end
    end
  end

  // Quotient register: cleared on accept, filled one bit per division step
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if ((state_r == IDLE) && in_valid) begin
      q_r <= '0;
    end else if (state_r == BUSY) begin
      q_r <= q_nxt_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign out_q = q_r;
`else
  // Without the quotient, the leading d bits of work_r only steer the division.
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_x     = work_r[d:7+d];

endmodule

// File: doc/red_mod_p.md
# red_mod_p

Serial reducer that maps an (8+d)-bit redundant-domain byte back into GF(2^8) by polynomial long division by the field polynomial P, one quotient bit per cycle. It is the inverse of the r·P expansion used on the masking side of the RAMBAM S-box datapath. An input word w = x + r·P yields remainder x (the GF(2^8) byte) and quotient r (the mask). It sits at the output of the S-box-only datapath, feeding unmasked bytes to the checker and bench.

## Interface
Parameters:
- d, default `d: redundancy degree, quotient width; d ≥ 1.
- P, default `P: 9-bit field polynomial, bit 0 = x^8 coefficient (AES: 9'b100011011).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  [0:7+d]  redundant word; index 0 is the highest-degree coefficient (x^(7+d)).
- out_valid  out  1  out_x (and out_q) hold a result.
- out_ready  in  1  consumer accepts the result.
- out_x  out  [0:7]  remainder of in_data mod P; index 0 = x^7.
- out_q  out  [0:d-1]  quotient. Present only with RED_QUOTIENT_EN.

## Operation
- Registers:
  - work [0:7+d]
  - q [0:d-1]
  - step counter, ceil(log2(d+1)) bits
  - state ∈ {IDLE, BUSY, DONE}
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: work←in_data, q←0, step←0, go BUSY.
- BUSY (i = step):
  - q[i]←work[i].
  - If work[i]=1, work[i +: 9] ^= P.
  - step←i+1.
  - When i = d-1, go DONE after this update.
- DONE:
  - out_valid=1.
  - out_x = work[d:7+d]; out_q = q.
  - On out_ready, go IDLE.
- After division, work[0:d-1] must be zero. Bits above the current step are never touched again.
- in_data is ignored whenever in_ready=0. in_valid held high during BUSY/DONE has no effect.
- Arithmetic is GF(2): XOR only, no carries. P[0]=1 is required, so each step clears work[i].
- Reset (at any time, including mid-BUSY or in DONE):
  - state←IDLE, work←0, q←0, step←0.
  - out_valid=0, in_ready=1 the cycle after the reset edge.
  - The in-flight word is discarded.
  - in_valid sampled on the same edge as rst=1 is ignored.

## Timing
- Accept edge A (in_valid & in_ready): state becomes BUSY.
- Division steps occur on edges A+1 … A+d.
- out_valid is high from edge A+d until the edge where out_ready=1 is sampled.
- Latency: d cycles from accept edge to out_valid.
- out_x/out_q are stable while out_valid=1.
- Consumer handshake edge C: state IDLE, in_ready=1 from C.
  - The next accept is possible at edge C+1.
- Throughput: one word per d+2 cycles with out_ready tied high.
- in_ready and out_valid are registered-state decodes and are mutually exclusive. in_ready=0 in BUSY and DONE.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- RED_QUOTIENT_EN defined:
  - out_q port and q register exist.
  - out_q = recovered mask r, valid with out_valid.
- RED_QUOTIENT_EN undefined:
  - out_q port and q register are removed.
  - The remainder path, handshake and timing are identical.
- With the macro, the bench checks in_data == out_q·P ⊕ {d'b0, out_x} for every result.

## Test plan
All scenarios use d=4, P=9'b100011011.
- Plain byte: in_data=12'h053, out_ready=1 → out_x=8'h53, out_q=4'b0000; out_valid exactly 4 cycles after the accept edge.
- Lowest mask bit: in_data=12'h11B (r=0001) → out_x=8'h00, out_q=4'b0001.
- Top mask bit plus data: in_data=12'h88B (=8D8⊕053) → out_x=8'h53, out_q=4'b1000.
- Backpressure: hold out_ready=0 for 5 cycles after the result appears.
  - out_valid and out_x stay constant and in_ready stays 0.
  - A second in_valid in this window is not accepted.
  - Release → IDLE on the next edge, then the next word is accepted.
- Reset mid-BUSY: assert rst after 2 steps.
  - Next cycle: out_valid=0, in_ready=1.
  - A following word 12'h11B still yields out_x=8'h00.
- Random: 1000 pairs (x,r) with in_data = r·P ⊕ x, and random out_ready.
  - Every out_x = x, and out_q = r under RED_QUOTIENT_EN.
  - No result is dropped or duplicated.
